subinst_rr_arbiter: RTL and testbench
=====================================

// Module: subinst_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream stream port among the NUM_REQ
//  (default 5) leaf instances of a root-module subtree (inst_0..inst_4).
//  - Grants one requester at a time and holds the grant for a whole burst.
//  - Passes that requester's valid/data/last through to the shared port.
//  - Forces a release after MAX_BURST beats so that no leaf can starve the others.
//  - Sits in the parent module, between the children and the shared resource.
// PARAMETERS
//  NUM_REQ    5   number of requesters (>=2)
//  DATA_W     32  width of one data beat
//  MAX_BURST  8   maximum accepted beats per grant before a forced release (>=1)
//  IDX_W      $clog2(NUM_REQ)  width of the source index (derived, not overridden)
// PORTS
//  clk        in   1               single clock, all logic on rising edge
//  rst        in   1               synchronous, active-high reset
//  req_valid  in   NUM_REQ         per-requester beat valid
//  req_data   in   NUM_REQ*DATA_W  packed beats; requester i is at [i*DATA_W +: DATA_W]
//  req_last   in   NUM_REQ         per-requester end-of-burst flag
//  req_ready  out  NUM_REQ         per-requester accept (one-hot or zero)
//  out_valid  out  1               shared-port beat valid
//  out_data   out  DATA_W          shared-port beat
//  out_last   out  1               shared-port last (copy of the granted requester's req_last)
//  out_ready  in   1               shared-port accept
//  out_src    out  IDX_W           index of the granted requester
//  busy       out  1               high while a grant is held
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0.
//    Outputs: out_valid=0, req_ready=0, out_src=0, busy=0, out_last=0, out_data=0.
//  - Beat acceptance is valid&&ready. When not granted, req_valid may be held high
//    indefinitely; the arbiter never drops it.
//  - State IDLE:
//    - No req_valid bit set: stay in IDLE.
//    - Otherwise pick the first set bit searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//    - Register the winner as grant_idx, clear beat_cnt, go to GRANT.
//    - Arbitration costs 1 bubble cycle: no beat passes in IDLE.
//  - State GRANT (g = grant_idx):
//    - Passthrough: out_valid=req_valid[g]; out_data=req_data[g]; out_last=req_last[g].
//    - req_ready = one-hot(g) & {NUM_REQ{out_ready}}.
//    - busy=1; out_src=g.
//    - Each accepted beat increments beat_cnt.
//    - Release when an accepted beat has req_last=1, or when it is the
//      MAX_BURST-th accepted beat (forced release; out_last is not altered).
//    - On release: go to IDLE; rr_ptr = (g==NUM_REQ-1) ? 0 : g+1.
//    - If the granted requester deasserts req_valid mid-burst, the grant is still held.
//  - Outside GRANT: out_valid=0, req_ready=0, out_data=0, out_last=0.
//  - Boundaries:
//    - rr_ptr wraps from NUM_REQ-1 to 0.
//    - Release and new requests in the same cycle: the new requests are
//      evaluated in the next IDLE cycle, using the updated rr_ptr.
//    - Single requester continuously valid: granted every other cycle pair
//      (IDLE, GRANT...), i.e. a 1-cycle gap between bursts.
//    - A burst of exactly MAX_BURST beats with last on the final beat is one
//      release, not two.
//    - beat_cnt width is $clog2(MAX_BURST+1); it never exceeds MAX_BURST.
//    - rst asserted mid-burst: next cycle is the reset state. In-flight beats are
//      abandoned; no req_ready is asserted in the reset cycle.
// STRUCTURE
//  - Package subinst_arb_pkg: typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t.
//  - One sub-module: rr_priority_pick (combinational).
//    - Inputs: req vector, rr_ptr.
//    - Outputs: winner idx, any_req.
//    - Implemented as a double-width masked priority encode.
//  - The top holds the FSM, rr_ptr, grant_idx, beat_cnt and the output mux.
// TESTING
//  - Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, out_valid=0,
//    busy=0, out_src=0.
//  - Rotation: req_valid=5'b11111, every requester sends 1-beat bursts (last=1),
//    out_ready=1 -> out_src sequence 0,1,2,3,4,0; one IDLE gap between each.
//  - Pointer skip: after a grant to 1, req_valid=5'b00001 -> grant 0.
//    After a grant to 4, req_valid=5'b10001 -> grant 0 (wrap), not 4.
//  - Forced release: requester 2 holds valid with last=0, MAX_BURST=8, out_ready=1
//    -> exactly 8 beats accepted, then IDLE, then grant 3 if req_valid[3]=1.
//  - Backpressure: during a grant to 3, out_ready toggles 1,0,0,1 on a 2-beat burst
//    (data A5A5_0001 then A5A5_0002, last on the 2nd) -> out_data holds stable while
//    stalled; exactly 2 accepts; release after the 2nd accept.
//  - Reset mid-burst: rst=1 after the 3rd beat of a grant to 1 -> busy=0 on the next
//    cycle; rr_ptr=0; the next arbitration starts from requester 0.

Source files
------------

// File: rtl/subinst_arb_pkg.sv
// Shared types for the subtree round-robin arbiter.
package subinst_arb_pkg;

    // Arbiter control state: choosing a winner, or holding a grant for a burst.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: lowest set request at or after rr_ptr,
// wrapping back through the lower indices when nothing above the pointer is set.
module rr_priority_pick #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    localparam int DBL_W = 2 * NUM_REQ;
    localparam int POS_W = $clog2(DBL_W);

    logic [NUM_REQ-1:0] mask;
    logic [DBL_W-1:0]   dbl;
    logic [POS_W-1:0]   pos;

    // Lower half keeps only requests at or above the pointer; upper half holds the
    // full vector, so the lowest set bit overall is the round-robin winner.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask[i] = (IDX_W'(i) >= rr_ptr);
        end
        dbl = {req, req & mask};
    end

    // Lowest-index set bit of the doubled vector, folded back into requester range.
    always_comb begin
        pos = '0;
        for (int i = DBL_W - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                pos = POS_W'(i);
            end
        end
        if (pos >= POS_W'(NUM_REQ)) begin
            winner = IDX_W'(pos - POS_W'(NUM_REQ));
        end else begin
            winner = IDX_W'(pos);
        end
        any_req = |req;
    end

endmodule

// File: rtl/subinst_rr_arbiter.sv
// Round-robin arbiter sharing one downstream stream port among the leaf
// instances of a subtree. A grant is held for a whole burst and released on
// last, or forcibly after MAX_BURST accepted beats.
module subinst_rr_arbiter
    import subinst_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 5,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BURST = 8,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_src,
    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic               sel_valid;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic               granted;
    logic               accept;
    logic               release_now;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    // Select the granted requester's beat and decide whether this cycle ends the burst.
    // A cycle with rst high never counts as granted, so no handshake leaks out of it.
    always_comb begin
        sel_valid   = req_valid[grant_idx_q];
        sel_last    = req_last[grant_idx_q];
        sel_data    = req_data[grant_idx_q*DATA_W +: DATA_W];
        granted     = (state_q == ARB_GRANT) && !rst;
        accept      = granted && sel_valid && out_ready;
        release_now = accept &&
                      (sel_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));
    end

    // Shared-port passthrough while granted; everything quiet otherwise.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        out_src   = '0;
        busy      = 1'b0;
        if (granted) begin
            out_valid = sel_valid;
            out_data  = sel_data;
            out_last  = sel_last;
            req_ready = out_ready ? (NUM_REQ'(1) << grant_idx_q) : '0;
            out_src   = grant_idx_q;
            busy      = 1'b1;
        end
    end

    // Next-state: arbitrate in IDLE (one bubble), count beats and release in GRANT.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_idx_d = pick_idx;
                    beat_cnt_d  = '0;
                    state_d     = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // Last and the MAX_BURST-th beat coinciding is still a single release.
                if (release_now) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset; an in-flight burst is simply abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_subinst_rr_arbiter.sv
// Self-checking bench for subinst_rr_arbiter: directed scenarios plus a random
// phase, each cycle compared against a transaction-level reference model.
module tb_subinst_rr_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic [IW-1:0]   out_src;
    logic            busy;

    always #5 clk = ~clk;

    subinst_rr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .out_src   (out_src),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the port, where the search starts, beats so far.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    // Observations taken from the DUT for scenario-level checks.
    int            grants[$];
    int            acc_by_src[N];
    bit            prev_busy = 1'b0;
    logic [DW-1:0] seen_data;

    function automatic logic [DW-1:0] beat_of(int i);
        return req_data[i*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = $urandom;
        end
    endtask

    task automatic clear_acc();
        for (int i = 0; i < N; i++) acc_by_src[i] = 0;
    endtask

    // One clock: compare outputs against the model, log DUT events, advance the model.
    task automatic step();
        logic [N-1:0]  e_ready;
        logic          e_valid;
        logic          e_last;
        logic          e_busy;
        logic [DW-1:0] e_data;
        int            e_src;
        @(negedge clk);
        e_ready = '0;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_busy  = 1'b0;
        e_data  = '0;
        e_src   = 0;
        if (!rst && m_busy) begin
            e_busy  = 1'b1;
            e_src   = m_owner;
            e_valid = req_valid[m_owner];
            e_data  = beat_of(m_owner);
            e_last  = req_last[m_owner];
            if (out_ready) e_ready[m_owner] = 1'b1;
        end
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("out_data",  64'(out_data),  64'(e_data));
        chk("out_last",  64'(out_last),  64'(e_last));
        chk("busy",      64'(busy),      64'(e_busy));
        chk("out_src",   64'(out_src),   64'(e_src));

        if (busy === 1'b1 && !prev_busy) grants.push_back(int'(out_src));
        prev_busy = (busy === 1'b1);
        if (busy === 1'b1 && out_valid === 1'b1 && out_ready) acc_by_src[out_src]++;
        seen_data = out_data;

        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
        end else if (m_busy) begin
            if (req_valid[m_owner] && out_ready) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == MB) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req_valid[c]) begin
                    m_busy = 1'b1; m_owner = c; m_beats = 0;
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int grant_at(int i);
        return (i < grants.size()) ? grants[i] : -1;
    endfunction

    initial begin
        int exp_rot[6] = '{0, 1, 2, 3, 4, 0};
        int n0;

        // Reset with every requester asking.
        rst = 1'b1; req_valid = '1; req_last = '0; out_ready = 1'b1;
        rand_data();
        step();
        step();
        rst = 1'b0;

        // Rotation: single-beat bursts from everybody.
        req_valid = '1; req_last = '1; grants.delete();
        repeat (12) begin rand_data(); step(); end
        chk("rot_count", 64'(grants.size()), 64'(6));
        for (int i = 0; i < 6; i++) chk("rot_src", 64'(grant_at(i)), 64'(exp_rot[i]));

        // Pointer skip and wrap.
        n0 = grants.size();
        req_valid = 5'b00010; repeat (2) step();
        chk("skip_g1", 64'(grant_at(n0)), 64'(1));
        req_valid = 5'b00001; repeat (2) step();
        chk("skip_g0", 64'(grant_at(n0 + 1)), 64'(0));
        req_valid = 5'b10000; repeat (2) step();
        chk("skip_g4", 64'(grant_at(n0 + 2)), 64'(4));
        req_valid = 5'b10001; repeat (2) step();
        chk("wrap_g0", 64'(grant_at(n0 + 3)), 64'(0));

        // Forced release: requester 2 never sends last.
        n0 = grants.size(); clear_acc();
        req_valid = 5'b01100; req_last = 5'b01000;
        repeat (11) begin rand_data(); step(); end
        chk("force_acc2", 64'(acc_by_src[2]), 64'(MB));
        chk("force_g2",   64'(grant_at(n0)),     64'(2));
        chk("force_g3",   64'(grant_at(n0 + 1)), 64'(3));
        chk("force_acc3", 64'(acc_by_src[3]), 64'(1));

        // Backpressure on a 2-beat burst from requester 3.
        n0 = grants.size(); clear_acc();
        req_valid = 5'b01000; req_last = 5'b00000; out_ready = 1'b1;
        req_data[3*DW +: DW] = 32'hA5A5_0001;
        step();
        step();
        chk("bp_beat1", 64'(seen_data), 64'(32'hA5A5_0001));
        req_data[3*DW +: DW] = 32'hA5A5_0002; req_last = 5'b01000;
        out_ready = 1'b0; step();
        chk("bp_stall1", 64'(seen_data), 64'(32'hA5A5_0002));
        step();
        chk("bp_stall2", 64'(seen_data), 64'(32'hA5A5_0002));
        out_ready = 1'b1; step();
        chk("bp_acc", 64'(acc_by_src[3]), 64'(2));
        chk("bp_g3",  64'(grant_at(n0)), 64'(3));
        req_valid = '0; step();
        chk("bp_released", 64'(prev_busy), 64'(0));

        // Reset in the middle of a burst from requester 1.
        n0 = grants.size();
        req_valid = 5'b00010; req_last = '0; out_ready = 1'b1;
        repeat (4) begin rand_data(); step(); end
        chk("mid_g1", 64'(grant_at(n0)), 64'(1));
        rst = 1'b1; step();
        rst = 1'b0; req_valid = '1; req_last = '1;
        step();
        chk("mid_idle", 64'(prev_busy), 64'(0));
        step();
        chk("mid_restart_g0", 64'(grant_at(n0 + 1)), 64'(0));

        // Random traffic with occasional resets.
        repeat (400) begin
            rst       = ($urandom_range(0, 63) == 0);
            req_valid = N'($urandom);
            req_last  = N'($urandom) & N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
